// File: rtl/mux_round_robin_arb.sv
// Round-robin arbiter for one shared line: 16 requesters, one grant at a time, and f = w[s] through a tree of 4:1 muxes.
// Define MUXARB_TIMEOUT_EN to add the HOLD-cycle grant limit. With the macro undefined, timeout stays 0.
module mux_round_robin_arb #(
  parameter int HOLD = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] req,
  input  logic        done,
  input  logic [15:0] w,
  output logic [3:0]  s,
  output logic [15:0] gnt,
  output logic        valid,
  output logic        f,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

`ifdef MUXARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t      state, next_state;
  logic [3:0]  ptr;
  logic [3:0]  cnt;
  logic [3:0]  pick;
  logic [3:0]  idx;
  logic        any_req;
  logic        hold_hit;
  logic        release_now;
  logic [3:0]  stage1;
  logic        mux_out;

  // Scan upward from ptr, wrapping from 15 to 0. The first request found wins.
  always_comb begin
    pick    = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = ptr + 4'(k);
      if (!any_req && req[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

  assign hold_hit    = TIMEOUT_EN && (cnt == HOLD_LAST);
  assign release_now = done || !req[s] || hold_hit;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req)     next_state = GRANT;
      GRANT:   if (release_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // s is registered and keeps its value after release. ptr moves past the holder that just released.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s   <= '0;
      gnt <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            s   <= pick;
            gnt <= 16'd1 << pick;
            cnt <= '0;
          end
        end
        GRANT: begin
          if (cnt != 4'hF) cnt <= cnt + 4'd1;
          if (release_now) begin
            gnt <= '0;
            ptr <= s + 4'd1;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end

  always_comb begin
    for (int g = 0; g < 4; g++) stage1[g] = w[4*g + int'(s[1:0])];
    mux_out = stage1[s[3:2]];
  end

  always_comb begin
    valid   = (state == GRANT);
    timeout = valid && hold_hit;
    f       = valid && mux_out;
  end

endmodule

// File: tb/tb_mux_round_robin_arb.sv
// Directed bench for mux_round_robin_arb. It covers reset, single grant, rotation, wrap, hold limit and async reset.
module tb_mux_round_robin_arb;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] req;
  logic        done;
  logic [15:0] w;
  logic [3:0]  s;
  logic [15:0] gnt;
  logic        valid;
  logic        f;
  logic        timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  mux_round_robin_arb #(.HOLD(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .done(done), .w(w),
    .s(s), .gnt(gnt), .valid(valid), .f(f), .timeout(timeout)
  );

  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic [15:0] req_v, input logic done_v, input logic [15:0] w_v);
    req  = req_v;
    done = done_v;
    w    = w_v;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b0;
    applyStimulus(16'h0000, 1'b0, 16'h0000);
    #12;
    checkOutput("rst_valid", {15'b0, valid}, 16'd0);
    checkOutput("rst_gnt", gnt, 16'h0000);
    checkOutput("rst_s", {12'b0, s}, 16'd0);
    checkOutput("rst_timeout", {15'b0, timeout}, 16'd0);
    checkOutput("rst_f", {15'b0, f}, 16'd0);

    Resetn = 1'b1;
    tick();
    checkOutput("idle_valid", {15'b0, valid}, 16'd0);

    // Single request to index 4. f should follow w[4].
    applyStimulus(16'h0010, 1'b0, 16'h0010);
    tick();
    checkOutput("single_valid", {15'b0, valid}, 16'd1);
    checkOutput("single_s", {12'b0, s}, 16'd4);
    checkOutput("single_gnt", gnt, 16'h0010);
    checkOutput("single_f1", {15'b0, f}, 16'd1);
    applyStimulus(16'h0010, 1'b0, 16'hFFEF);
    #1;
    checkOutput("single_f0", {15'b0, f}, 16'd0);
    applyStimulus(16'h0010, 1'b1, 16'hFFFF);
    tick();
    checkOutput("rel_valid", {15'b0, valid}, 16'd0);
    checkOutput("rel_gnt", gnt, 16'h0000);
    checkOutput("rel_s_hold", {12'b0, s}, 16'd4);
    checkOutput("rel_f", {15'b0, f}, 16'd0);

    // Reset again so that the rotation starts from index 0.
    Resetn = 1'b0;
    #2;
    Resetn = 1'b1;
    applyStimulus(16'hFFFF, 1'b0, 16'hAAAA);
    for (int i = 0; i < 17; i++) begin
      tick();
      checkOutput($sformatf("rot%0d_valid", i), {15'b0, valid}, 16'd1);
      checkOutput($sformatf("rot%0d_s", i), {12'b0, s}, 16'(i % 16));
      checkOutput($sformatf("rot%0d_gnt", i), gnt, 16'd1 << (i % 16));
      checkOutput($sformatf("rot%0d_f", i), {15'b0, f}, 16'(i % 2));
      applyStimulus(16'hFFFF, 1'b1, 16'hAAAA);
      tick();
      checkOutput($sformatf("rot%0d_gap", i), {15'b0, valid}, 16'd0);
      applyStimulus(16'hFFFF, 1'b0, 16'hAAAA);
    end

    // The pointer is now 1. Grant 14 moves the pointer to 15, so the next scan is 15, then 0.
    applyStimulus(16'h4000, 1'b0, 16'h0000);
    tick();
    checkOutput("wrap_s14", {12'b0, s}, 16'd14);
    applyStimulus(16'h4000, 1'b1, 16'h0000);
    tick();
    checkOutput("wrap_gap0", {15'b0, valid}, 16'd0);
    applyStimulus(16'h8001, 1'b0, 16'h0000);
    tick();
    checkOutput("wrap_s15", {12'b0, s}, 16'd15);
    applyStimulus(16'hC003, 1'b0, 16'h0000);
    tick();
    checkOutput("hold_s15", {12'b0, s}, 16'd15);
    checkOutput("hold_gnt15", gnt, 16'h8000);
    checkOutput("hold_valid", {15'b0, valid}, 16'd1);
    applyStimulus(16'h0001, 1'b0, 16'h0000);
    tick();
    checkOutput("reqdrop_valid", {15'b0, valid}, 16'd0);
    tick();
    checkOutput("wrap_s0", {12'b0, s}, 16'd0);
    checkOutput("wrap_gnt0", gnt, 16'h0001);
    applyStimulus(16'h0001, 1'b1, 16'h0000);
    tick();
    checkOutput("wrap_gap1", {15'b0, valid}, 16'd0);

    // Hold a single request with done low.
    applyStimulus(16'h0001, 1'b0, 16'h0000);
    tick();
`ifdef MUXARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("tmo%0d_valid", k), {15'b0, valid}, 16'd1);
      checkOutput($sformatf("tmo%0d_pulse", k), {15'b0, timeout}, (k == 3) ? 16'd1 : 16'd0);
    end
    tick();
    checkOutput("tmo_gap_valid", {15'b0, valid}, 16'd0);
    checkOutput("tmo_gap_pulse", {15'b0, timeout}, 16'd0);
    tick();
    checkOutput("tmo_regrant_valid", {15'b0, valid}, 16'd1);
    checkOutput("tmo_regrant_s", {12'b0, s}, 16'd0);
`else
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("notmo%0d_valid", k), {15'b0, valid}, 16'd1);
      checkOutput($sformatf("notmo%0d_pulse", k), {15'b0, timeout}, 16'd0);
    end
`endif
    applyStimulus(16'h0001, 1'b1, 16'h0000);
    tick();
    checkOutput("long_rel_valid", {15'b0, valid}, 16'd0);
    checkOutput("long_rel_pulse", {15'b0, timeout}, 16'd0);

    // Drop reset between clock edges while index 9 holds the grant.
    applyStimulus(16'h0200, 1'b0, 16'h0000);
    tick();
    checkOutput("pre_rst_s9", {12'b0, s}, 16'd9);
    #3;
    Resetn = 1'b0;
    #1;
    checkOutput("arst_valid", {15'b0, valid}, 16'd0);
    checkOutput("arst_gnt", gnt, 16'h0000);
    checkOutput("arst_s", {12'b0, s}, 16'd0);
    checkOutput("arst_timeout", {15'b0, timeout}, 16'd0);
    applyStimulus(16'h0201, 1'b0, 16'h0000);
    Resetn = 1'b1;
    tick();
    checkOutput("post_rst_s", {12'b0, s}, 16'd0);
    checkOutput("post_rst_gnt", gnt, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_round_robin_arb.md
MUX_ROUND_ROBIN_ARB -- requirements
Module: mux_round_robin_arb

Interface
REQ-001 SHALL have parameter HOLD, default 4, giving the maximum grant length in cycles when timeout is compiled in; legal range 1..15.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 16 bits: per-requester request lines; req[i] high means requester i wants the shared line.
REQ-005 SHALL have port done, input, 1 bit: the current grant holder releases the line when this is high.
REQ-006 SHALL have port w, input, 16 bits: data bits, one per requester.
REQ-007 SHALL have port s, output, 4 bits: registered select code of the current grant holder.
REQ-008 SHALL have port gnt, output, 16 bits: one-hot grant; all zero when no grant is active.
REQ-009 SHALL have port valid, output, 1 bit: high while a grant is active.
REQ-010 SHALL have port f, output, 1 bit: shared output, equal to w[s] when valid is high and 0 otherwise; combinational from w.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 In IDLE with req equal to 0, the FSM SHALL remain in IDLE, with valid=0 and gnt=0.
REQ-014 In IDLE with req not equal to 0, it SHALL select the first asserted req[i] scanning upward from priority pointer ptr, wrapping 15->0.
- It SHALL load s=i and gnt=1<<i, set valid=1 and enter GRANT on the next edge.
- Latency from req assertion to valid is 1 cycle.
REQ-015 In GRANT, it SHALL release when done=1 or req[s]=0; a release SHALL take effect on the next edge.
REQ-016 On release it SHALL:
- return to IDLE;
- clear valid and gnt;
- set ptr=(s+1) mod 16, so index 15 wraps to 0.
- s SHALL hold its last value.
REQ-017 Exactly one idle cycle (valid=0) SHALL separate consecutive grants, even when other requests are pending.
REQ-018 Requests that change during GRANT SHALL NOT affect the holder, except via the req[s]=0 release condition.
REQ-019 The output f SHALL be produced by a 16:1 multiplexer built from five 4:1 stages:
- four first-level stages on s[1:0];
- one second-level stage on s[3:2].
REQ-020 A 4-bit hold counter SHALL reset to 0 on grant entry and increment each GRANT cycle, saturating at 15.
REQ-021 When release and timeout occur in the same cycle, both SHALL act: the FSM goes to IDLE and timeout pulses 1.

Reset
REQ-022 Resetn=0 SHALL immediately force: state=IDLE, ptr=0, s=0, gnt=0, valid=0, timeout=0, hold counter=0.
REQ-023 Reset asserted during GRANT SHALL drop the grant without a timeout pulse; the first grant after reset SHALL scan from index 0.

Configuration
REQ-024 Macro MUXARB_TIMEOUT_EN defined SHALL enable the hold limit:
- when the counter reaches HOLD-1 in GRANT, the grant is released on the next edge;
- timeout=1 during that release cycle;
- ptr advances as for a normal release.
REQ-025 Macro MUXARB_TIMEOUT_EN undefined SHALL mean:
- no hold limit; the grant persists until done or req[s]=0;
- timeout is tied to 0;
- the counter may be omitted.

Verification
REQ-026 Scenario, reset and single request: Resetn low then high; req=16'h0010 -> valid=1, s=4, gnt=16'h0010 one cycle later, and f follows w[4].
REQ-027 Scenario, rotation: req=16'hFFFF held, with done pulsed each grant -> grant order 0,1,2,...,15,0, with one valid=0 cycle between each grant.
REQ-028 Scenario, wrap fairness: ptr=15 after a grant to 14; req=16'h8001 -> grant to 15 first, then to 0.
REQ-029 Scenario, timeout (MUXARB_TIMEOUT_EN, HOLD=4): req=16'h0001 held, done=0 -> valid high for exactly 4 cycles, timeout pulses once, next grant to 0 after one idle cycle.
REQ-030 Scenario, no macro: same stimulus as REQ-029 -> valid stays high indefinitely and timeout is always 0.
REQ-031 Scenario, asynchronous reset mid-grant: Resetn dropped between edges during GRANT with s=9 -> valid, gnt and s read 0 before the next edge; the next grant scans from 0.
